// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave word RAM that stretches every access with programmable
// wait states, flags bad accesses on a sticky error and counts completions.
module avalon_wait_ram #(
  parameter int          ADDR_BITS     = 12,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int          WAIT_CYCLES   = 2,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        bus_error,
  output logic [31:0] access_count
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic       ONE_WAIT = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [31:0]            addr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic [3:0]             be_q;
  logic                   rd_q;
  logic                   wr_q;
  logic                   err_q;
  logic [31:0]            mem [DEPTH];

  logic                   req;
  logic                   changed;
  logic [31:0]            off;
  logic [ADDR_BITS-1:0]   live_idx;
  logic                   live_err;
  logic                   load;
  logic                   go_ack;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic                   cur_rd;
  logic                   cur_err;

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = 32'h0;
  end

  assign req         = read | write;
  assign waitrequest = req && (state != ACK);
  assign changed     = (address != addr_q) || (read != rd_q)
                    || (write != wr_q);

  assign off      = address - BASE_ADDR;
  assign live_idx = off[ADDR_BITS+1:2];
  assign live_err = (off[1:0] != 2'b00)
                 || (off[31:ADDR_BITS+2] != '0)
                 || (read && write);

  // A changed request in WAIT is a fresh access: reload and recount.
  always_comb begin
    load   = 1'b0;
    go_ack = 1'b0;
    unique case (state)
      IDLE:    load = req;
      WAIT:    load = req && changed;
      default: load = 1'b0;
    endcase
    if (load)
      go_ack = ONE_WAIT;
    else
      go_ack = (state == WAIT) && req && (cnt <= 4'd1);
  end

  assign cur_idx = load ? live_idx : idx_q;
  assign cur_rd  = load ? read     : rd_q;
  assign cur_err = load ? live_err : err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_q       <= 32'h0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      readdata     <= 32'h0;
      bus_error    <= 1'b0;
      access_count <= 32'h0;
    end else begin
      if (load) begin
        addr_q  <= address;
        idx_q   <= live_idx;
        rd_q    <= read;
        wr_q    <= write;
        err_q   <= live_err;
        wdata_q <= writedata;
        be_q    <= byteenable;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (go_ack)
        readdata <= (cur_rd && !cur_err) ? mem[cur_idx] : 32'h0;
      unique case (state)
        IDLE: begin
          if (req)
            state <= ONE_WAIT ? ACK : WAIT;
        end
        WAIT: begin
          if (!req)
            state <= IDLE;
          else if (go_ack)
            state <= ACK;
        end
        ACK: begin
          state        <= IDLE;
          access_count <= access_count + 32'd1;
          if (err_q)
            bus_error <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == ACK && wr_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
